// File: rtl/fir_sample_serializer.sv
// fir_sample_serializer
//
// Transmit-side partner of the fir_filter sample interface. Parallel samples
// arrive on the i_en/iv_din strobe interface and are buffered in a small FIFO.
// They leave as a continuous left-justified serial stream made of a bit clock,
// a word select and serial data, for an external DAC or codec. Back-to-back
// words are gapless, so the word period is exactly DATA_WIDTH*CLK_DIV cycles.
//
// Parameters:
//   DATA_WIDTH - sample width in bits; one word is DATA_WIDTH serial bits
//   FIFO_DEPTH - sample buffer entries (power of two, >= 2)
//   CLK_DIV    - i_clk cycles per serial bit (even, >= 2)
//
// Ports:
//   i_clk      - system clock; all logic runs on its rising edge
//   i_rst      - synchronous reset, active low
//   i_en       - sample strobe; iv_din is valid in the same cycle
//   iv_din     - parallel two's complement sample
//   o_full     - FIFO full (registered); strobes are dropped while it is high
//   o_busy     - serializer is not idle
//   o_sck      - serial bit clock
//   o_ws       - word select; toggles on the first bit of each word
//   o_sd       - serial data (MSB first by default)
//   o_overflow - one-cycle pulse when a strobe was dropped
//   o_underrun - one-cycle pulse when a word ended with the FIFO empty
//
// Build option:
//   FIR_SER_LSB_FIRST_EN - when defined, each word is shifted LSB first.
//                          Framing and timing are the same in both builds.

module fir_sample_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_din,
  output logic                  o_full,
  output logic                  o_busy,
  output logic                  o_sck,
  output logic                  o_ws,
  output logic                  o_sd,
  output logic                  o_overflow,
  output logic                  o_underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  HALF_PH   = PH_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t                state, state_nxt;
  logic [PH_W-1:0]       phase, phase_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  ws_nxt, sd_nxt, sck_nxt, busy_nxt, underrun_nxt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  // Advance the shift register by one bit in the configured direction.
  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
`ifdef FIR_SER_LSB_FIRST_EN
    return {1'b0, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  // Bit of the shift register currently presented on the serial line.
  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
`ifdef FIR_SER_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_WIDTH-1];
`endif
  endfunction

  assign head = mem[rd_ptr];

  // A write into a full FIFO is dropped even when a pop happens in the same
  // cycle, because o_full is the registered flag and there is no bypass.
  assign push = i_en && !o_full;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Next-state and output logic. o_sd only changes when the phase counter
  // returns to 0 (sck falling), so the receiver samples on sck rising.
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    bit_nxt      = bit_cnt;
    shreg_nxt    = shreg;
    ws_nxt       = o_ws;
    sd_nxt       = o_sd;
    underrun_nxt = 1'b0;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (count != '0) state_nxt = LOAD;
      end
      LOAD: begin
        pop       = 1'b1;
        shreg_nxt = head;
        sd_nxt    = lead_bit(head);
        ws_nxt    = 1'b0;
        phase_nxt = '0;
        bit_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (phase == LAST_PH) begin
          phase_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            // Word boundary: reload straight from the FIFO to keep the
            // stream gapless, or stop if nothing is waiting.
            if (count != '0) begin
              pop       = 1'b1;
              shreg_nxt = head;
              sd_nxt    = lead_bit(head);
              ws_nxt    = ~o_ws;
              bit_nxt   = '0;
            end else begin
              state_nxt    = IDLE;
              underrun_nxt = 1'b1;
              bit_nxt      = '0;
            end
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            shreg_nxt = shift_word(shreg);
            sd_nxt    = lead_bit(shift_word(shreg));
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    sck_nxt  = (state_nxt == SHIFT) && (phase_nxt >= HALF_PH);
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counters, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_full     <= 1'b0;
      o_busy     <= 1'b0;
      o_sck      <= 1'b0;
      o_ws       <= 1'b0;
      o_sd       <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      count      <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      o_full     <= (count_nxt == DEPTH_C);
      o_busy     <= busy_nxt;
      o_sck      <= sck_nxt;
      o_ws       <= ws_nxt;
      o_sd       <= sd_nxt;
      o_overflow <= i_en && o_full;
      o_underrun <= underrun_nxt;
    end
  end

  // Sample storage needs no reset; the cleared count marks it empty.
  always_ff @(posedge i_clk) begin
    if (i_rst && push) mem[wr_ptr] <= iv_din;
  end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// tb_fir_sample_serializer
//
// Directed bench for fir_sample_serializer with DATA_WIDTH=8, FIFO_DEPTH=4,
// CLK_DIV=4. Inputs are driven 1 time unit after each rising edge and the
// outputs are sampled at the same point, away from the active edge.
// Honours FIR_SER_LSB_FIRST_EN so it matches the RTL build option.

module tb_fir_sample_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          full, busy, sck, ws, sd, overflow, underrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] words [0:7];
  int            nwords;

  fir_sample_serializer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4),
    .CLK_DIV   (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .iv_din    (din),
    .o_full    (full),
    .o_busy    (busy),
    .o_sck     (sck),
    .o_ws      (ws),
    .o_sd      (sd),
    .o_overflow(overflow),
    .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  // Expected {sd, sck, ws, busy, underrun} t cycles after the LOAD edge
  // (t = 0 is the first cycle with the first bit on o_sd). The block is
  // assumed to start from reset, and words[0..nwords-1] are sent in order.
  function automatic logic [4:0] exp_out(input int t);
    int   w, b, p;
    logic bitv, ph_hi, ws_v;
    if (t < -1) return 5'b00000;
    if (t == -1) return 5'b00010;
    if (t < 32 * nwords) begin
      w     = t / 32;
      b     = (t % 32) / 4;
      p     = t % 4;
`ifdef FIR_SER_LSB_FIRST_EN
      bitv  = words[w][b];
`else
      bitv  = words[w][7-b];
`endif
      ph_hi = (p >= 2);
      ws_v  = (w % 2 == 1);
      return {bitv, ph_hi, ws_v, 1'b1, 1'b0};
    end
`ifdef FIR_SER_LSB_FIRST_EN
    bitv = words[nwords-1][7];
`else
    bitv = words[nwords-1][0];
`endif
    ws_v = ((nwords - 1) % 2 == 1);
    return {bitv, 1'b0, ws_v, 1'b0, (t == 32 * nwords)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    en  = 1'b1;
    din = 8'hFF;
    tick();
    vectors++;
    if ({full, busy, sck, ws, sd, overflow, underrun} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %b want 0000000",
               {full, busy, sck, ws, sd, overflow, underrun});
    end
    tick();
    vectors++;
    if ({full, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ignores_strobe full/busy got %b want 00", {full, busy});
    end
    en  = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_fifo_empty busy got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    logic [4:0] e;
    reset_dut();
    words[0] = 8'hA5;
    nwords   = 1;
    for (int c = 0; c < 32 + 6; c++) begin
      en  = (c == 0);
      din = 8'hA5;
      tick();
      e = exp_out(c - 2);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL single c=%0d sd/sck/ws/busy/und got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
      vectors++;
      if ({full, overflow} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL single_flags c=%0d full/ovf got %b want 00", c, {full, overflow});
      end
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [4:0] e;
    reset_dut();
    words[0] = 8'h81;
    words[1] = 8'h7E;
    nwords   = 2;
    for (int c = 0; c < 64 + 6; c++) begin
      en  = (c < 2);
      din = (c < 2) ? words[c] : 8'h00;
      tick();
      e = exp_out(c - 2);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL back_to_back c=%0d sd/sck/ws/busy/und got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_overflow;
    logic [4:0] e;
    logic       e_full, e_ovf;
    reset_dut();
    for (int i = 0; i < 6; i++) words[i] = 8'(i + 1);
    nwords = 5;
    for (int c = 0; c < 160 + 6; c++) begin
      en  = (c < 6);
      din = (c < 6) ? words[c] : 8'h00;
      tick();
      e      = exp_out(c - 2);
      e_full = (c >= 4 && c <= 33);
      e_ovf  = (c == 5);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL overflow_stream c=%0d sd/sck/ws/busy/und got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
      vectors++;
      if ({full, overflow} !== {e_full, e_ovf}) begin
        miscompares++;
        $display("[TB] FAIL overflow_flags c=%0d full/ovf got %b want %b",
                 c, {full, overflow}, {e_full, e_ovf});
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_word;
    logic [4:0] e;
    reset_dut();
    words[0] = 8'hFF;
    nwords   = 1;
    for (int c = 0; c < 16; c++) begin
      en  = (c == 0);
      din = 8'hFF;
      tick();
      e = exp_out(c - 2);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL mid_word_pre c=%0d got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
    end
    en  = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if ({full, busy, sck, ws, sd, overflow, underrun} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_word_reset got %b want 0000000",
               {full, busy, sck, ws, sd, overflow, underrun});
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({full, busy, underrun} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL mid_word_empty full/busy/und got %b want 000", {full, busy, underrun});
    end
    words[0] = 8'h3C;
    for (int c = 0; c < 32 + 4; c++) begin
      en  = (c == 0);
      din = 8'h3C;
      tick();
      e = exp_out(c - 2);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL mid_word_after c=%0d got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
    end
    en = 1'b0;
  endtask

`ifdef FIR_SER_LSB_FIRST_EN
  task automatic test_lsb_first;
    logic [4:0] e;
    reset_dut();
    words[0] = 8'h01;
    nwords   = 1;
    for (int c = 0; c < 32 + 4; c++) begin
      en  = (c == 0);
      din = 8'h01;
      tick();
      e = exp_out(c - 2);
      vectors++;
      if ({sd, sck, ws, busy, underrun} !== e) begin
        miscompares++;
        $display("[TB] FAIL lsb_first c=%0d got %b want %b",
                 c, {sd, sck, ws, busy, underrun}, e);
      end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    din = '0;
    nwords = 1;
    for (int i = 0; i < 8; i++) words[i] = '0;
    #2;
    $display("[TB] start");
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_word();
`ifdef FIR_SER_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_sample_serializer.md
Name: fir_sample_serializer

Overview:
- Transmit-side counterpart to the FIR sample interface: accepts parallel samples on the `i_en`/`iv_din` strobe interface that the fir_filter block uses.
- Buffers samples in a small FIFO and shifts them out as a continuous left-justified serial stream (bit clock, word select, data) to an external DAC/codec.
- Sits directly downstream of fir_filter's output.

Parameters:
- DATA_WIDTH, 24, sample width in bits; one word = DATA_WIDTH serial bits.
- FIFO_DEPTH, 4, sample buffer entries; power of two, >=2.
- CLK_DIV, 4, i_clk cycles per serial bit; even, >=2.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-low.
- i_en  input  1  sample strobe; iv_din valid this cycle.
- iv_din  input  DATA_WIDTH  parallel sample, two's complement.
- o_full  output  1  FIFO full (registered); strobes while high are dropped.
- o_busy  output  1  serializer not IDLE.
- o_sck  output  1  serial bit clock.
- o_ws  output  1  word select; toggles at each word's first bit.
- o_sd  output  1  serial data, MSB first.
- o_overflow  output  1  one-cycle pulse: sample dropped (i_en while o_full).
- o_underrun  output  1  one-cycle pulse: word ended with FIFO empty, stream stopped.

Behaviour:
- Reset (i_rst=0 at an edge): FIFO emptied, state IDLE, bit/phase counters cleared. All outputs 0 (o_sck, o_ws, o_sd, o_full, o_busy, o_overflow, o_underrun). Reset mid-word aborts immediately; no partial word completes.
- All outputs are registered.
- FIFO write:
  - On i_en=1 with o_full=0, iv_din is written at that edge.
  - On i_en=1 with o_full=1, nothing is written and o_overflow pulses on the next cycle.
  - No bypass: a write into a full FIFO is dropped even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- State machine: IDLE, LOAD, SHIFT.
  - IDLE: o_busy=0, o_sck=0, o_ws and o_sd hold. Goes to LOAD when the FIFO is non-empty.
  - LOAD (1 cycle): pop head into the shift register and drive its MSB on o_sd. Set o_ws=0 if coming from IDLE, else toggle o_ws. Clear the phase counter and bit counter; go to SHIFT.
  - SHIFT: phase counter counts 0..CLK_DIV-1. o_sck=0 for phases 0..CLK_DIV/2-1 and 1 for the rest. o_sd changes only at phase 0 (sck falling), so the DAC samples on the sck rising edge.
  - On the last phase of bit DATA_WIDTH-1:
    - FIFO non-empty: pop the next sample, load it, toggle o_ws, and start the next word at phase 0 the following cycle. This is gapless: the word period is exactly DATA_WIDTH*CLK_DIV cycles.
    - FIFO empty: go to IDLE, pulse o_underrun, drive o_sck to 0.
  - The gapless reload is done in SHIFT; LOAD is used only when leaving IDLE.
- Latency: a strobe at edge E0 into an empty, IDLE block puts the MSB on o_sd after edge E0+2 (E0 write, E1 IDLE->LOAD, E2 LOAD).
- Sample data is transmitted bit-exact; no rounding or truncation.

Optional Feature:
- Macro FIR_SER_LSB_FIRST_EN.
- Defined: each word is shifted LSB first (bit 0 first, bit DATA_WIDTH-1 last); framing and timing are unchanged.
- Undefined: MSB first as above.

Test Plan:
- Bench settings: DATA_WIDTH=8, FIFO_DEPTH=4, CLK_DIV=4.
- Single sample: i_en with 0xA5 from IDLE -> o_sd=1,0,1,0,0,1,0,1, each held 4 cycles, first bit after E0+2; o_ws=0; o_sck period 4 (low 2, high 2); after bit 7, o_underrun pulses once, o_busy=0, o_sck=0.
- Back-to-back: 0x81 and 0x7E on consecutive cycles -> 16 contiguous bits 10000001 01111110, no gap; o_ws 0 then 1; a single o_underrun at the end.
- Overflow: six strobes on consecutive cycles, values 0x01..0x06, from IDLE -> o_full high after the 5th write; 0x06 dropped with one o_overflow pulse; 0x01..0x05 serialized in order; o_ws alternates 0,1,0,1,0.
- Reset mid-word: i_rst=0 for one cycle during bit 3 of 0xFF -> next cycle all outputs 0 and FIFO empty; a new 0x3C afterwards serializes cleanly with o_ws=0.
- Macro FIR_SER_LSB_FIRST_EN defined: sample 0x01 -> o_sd=1,0,0,0,0,0,0,0.
